// File: rtl/adder_pkg.sv
// Shared types and constants for the adder and its downstream frame accumulator.
package adder_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

  localparam int unsigned SAMPLE_W      = 5;
  localparam int unsigned DEF_FRAME_LEN = 16;
  localparam int unsigned DEF_ACC_W     = 8;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: ACC_W accumulator plus a zero-extended 5-bit sample.
module sat_add
  import adder_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]    sum,
  output logic                sat
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, acc} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample};
    sat  = wide[ACC_W];
    sum  = sat ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/adder_accumulator.sv
// Sums FRAME_LEN {carry,sum} samples with saturation and counts carries;
// each completed frame is held on a valid/ready output until taken.
module adder_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       s_in,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  acc_state_e state, state_next;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] carry_next;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             valid_next;

  logic [ACC_W-1:0] sum;
  logic             sat;
  logic             accept;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc   (acc_out),
    .sample({c_in, s_in}),
    .sum   (sum),
    .sat   (sat)
  );

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    carry_next = carry_cnt;
    acc_next   = acc_out;
    ovf_next   = overflow;
    valid_next = out_valid;

    if (clear) begin
      state_next = ACCUM;
      cnt_next   = '0;
      carry_next = '0;
      acc_next   = '0;
      ovf_next   = 1'b0;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            acc_next   = sum;
            ovf_next   = overflow | sat;
            carry_next = carry_cnt + CNT_W'(c_in);
            cnt_next   = cnt + 1'b1;
            if (cnt == CNT_W'(FRAME_LEN - 1)) begin
              state_next = DONE;
              valid_next = 1'b1;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state_next = ACCUM;
            cnt_next   = '0;
            carry_next = '0;
            acc_next   = '0;
            ovf_next   = 1'b0;
            valid_next = 1'b0;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      carry_cnt <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      carry_cnt <= carry_next;
      acc_out   <= acc_next;
      overflow  <= ovf_next;
      out_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed + randomized bench for adder_accumulator against an arithmetic frame model.
module tb_adder_accumulator;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned ACC_W     = 8;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned ACC_MAX   = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [3:0]       s_in = '0;
  logic             c_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] carry_cnt;
  logic             overflow;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model state
  int unsigned m_acc = 0;
  int unsigned m_carries = 0;
  int unsigned m_samples = 0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;

  adder_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .ACC_W    (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .s_in     (s_in),
    .c_in     (c_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .carry_cnt(carry_cnt),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_acc = 0; m_carries = 0; m_samples = 0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!m_done));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_done));
    chk({tag, ".acc_out"},   32'(acc_out),   m_acc);
    chk({tag, ".carry_cnt"}, 32'(carry_cnt), m_carries);
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  // One clock: drive at negedge, advance model, check 1 time unit after the rising edge.
  task automatic cycle(input string tag, input bit v, input logic [3:0] s, input bit c,
                       input bit ordy, input bit clr);
    int unsigned smp;
    @(negedge clk);
    in_valid = v; s_in = s; c_in = c; out_ready = ordy; clear = clr;
    smp = {27'd0, c, s};
    if (clr) begin
      model_zero();
    end else if (!m_done) begin
      if (v) begin
        if (m_acc + smp > ACC_MAX) begin
          m_acc = ACC_MAX;
          m_ovf = 1'b1;
        end else begin
          m_acc = m_acc + smp;
        end
        m_carries += c;
        m_samples++;
        if (m_samples == FRAME_LEN) m_done = 1'b1;
      end
    end else if (ordy) begin
      model_zero();
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; clear = 1'b0;
    #1;
    model_zero();
    check_all({tag, ".async"});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, ".release"});
  endtask

  initial begin
    // reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_zero();
    check_all("reset");

    // plain frame of 3s
    for (int i = 0; i < 16; i++) cycle("plain", 1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    chk("plain.total", 32'(acc_out), 48);
    chk("plain.done",  32'(out_valid), 1);
    cycle("plain.drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("plain.ready_back", 32'(in_ready), 1);

    // saturation
    for (int i = 0; i < 16; i++) begin
      cycle("sat", 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
      if (i == 7) chk("sat.8th", 32'(acc_out), 248);
      if (i == 8) chk("sat.9th", 32'(acc_out), 255);
    end
    chk("sat.overflow", 32'(overflow), 1);
    chk("sat.carries", 32'(carry_cnt), 16);
    cycle("sat.drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // bubbles with random samples, then backpressure while offering samples
    for (int i = 0; i < 32; i++)
      cycle("bubble", (i % 2) == 0, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    chk("bubble.done", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++)
      cycle("bp", 1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    cycle("bp.release", 1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
    chk("bp.fresh_acc", 32'(acc_out), 0);
    cycle("bp.first", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    chk("bp.first_acc", 32'(acc_out), 2);

    // abort with clear (sample offered on the clear cycle is dropped)
    cycle("pre_clr", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle("clr.part", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    cycle("clr", 1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    chk("clr.acc", 32'(acc_out), 0);
    for (int i = 0; i < 16; i++) cycle("clr.frame", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    chk("clr.total", 32'(acc_out), 16);
    cycle("clr.drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // abort with reset mid-frame
    for (int i = 0; i < 7; i++) cycle("rst.part", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    pulse_reset("rst");
    for (int i = 0; i < 16; i++) cycle("rst.frame", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    chk("rst.total", 32'(acc_out), 16);
    cycle("rst.drain", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // randomized traffic with occasional clear
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), $urandom_range(0, 60) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
# adder_accumulator

Frame accumulator sitting directly downstream of the 4-bit `adder`. It consumes the adder's sum `s` and carry `c` as a 5-bit sample `{c,s}` (0..31) under a valid/ready handshake. It sums `FRAME_LEN` accepted samples into a saturating accumulator and counts how many samples carried out. Each completed frame is presented on a held valid/ready output port.

## Interface

Parameters:
- `FRAME_LEN`, default 16: samples per frame; must be ≥ 2.
- `ACC_W`, default 8: accumulator width; saturates at 2^ACC_W−1.
- `CNT_W`, default `$clog2(FRAME_LEN+1)`: width of the carry and sample counters.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `clear`  in  1: synchronous frame abort.
- `s_in`  in  4: adder sum.
- `c_in`  in  1: adder carry.
- `in_valid`  in  1: sample present.
- `in_ready`  out  1: block accepts a sample.
- `acc_out`  out  ACC_W: frame total, saturated.
- `carry_cnt`  out  CNT_W: number of accepted samples with `c_in`=1.
- `overflow`  out  1: saturation occurred in this frame.
- `out_valid`  out  1: frame result available.
- `out_ready`  in  1: consumer takes the result.

## Operation

- States are `ACCUM` and `DONE`. Reset state is `ACCUM`.
- Reset values: `acc_out`=0, `carry_cnt`=0, `overflow`=0, `out_valid`=0, sample counter=0. `in_ready` is 1 once `rst_n` is high.
- `in_ready` = (state==`ACCUM`). It is decoded from the registered state only and never depends on `in_valid`.
- Accept = `in_valid && in_ready`. On accept:
  - acc ← sat(acc + {c_in,s_in}).
  - carry_cnt += c_in.
  - cnt += 1.
  - If the unsaturated sum exceeds 2^ACC_W−1, acc ← all ones and `overflow` ← 1. `overflow` is sticky until the frame ends.
- Cycles with `in_valid`=0 change nothing.
- Accept with cnt==FRAME_LEN−1 moves ACCUM→DONE and sets `out_valid`.
- In `DONE`:
  - `acc_out`, `carry_cnt` and `overflow` are stable.
  - `in_ready`=0, and `in_valid` is ignored.
  - On `out_valid && out_ready`, return to `ACCUM`. The same edge zeroes acc, carry_cnt, cnt and overflow and clears `out_valid`.
- `out_valid`, once high, stays high until the handshake completes. It is never withdrawn, except by `clear` or reset.
- `clear` has priority over everything. On the next edge: state→`ACCUM`, all counters, acc and flags go to 0, `out_valid`→0, and any sample offered that cycle is dropped.
- Asserting `rst_n` low in any state forces the reset values immediately. No partial frame survives.
- Saturation arithmetic:
  - Compute the sum in ACC_W+1 bits.
  - If the MSB is set, saturate.
  - The 5-bit sample is zero-extended.

## Timing

- Latency: the last sample is accepted at edge k, so `out_valid`=1 after edge k.
- Minimum frame period is FRAME_LEN+1 cycles (FRAME_LEN accepts plus one `DONE` cycle with `out_ready`=1).
- All outputs are registered except `in_ready`, which decodes the state register.
- No combinational path from `out_ready` or `in_valid` to any output.

## Structure

- Package `adder_pkg` holds:
  - the state enum (`ACCUM`, `DONE`);
  - `SAMPLE_W`=5;
  - default `FRAME_LEN` and `ACC_W` constants, shared with the `adder` bench.
- One sub-module, `sat_add`: parameterised ACC_W saturating adder with zero-extended 5-bit operand. It outputs the sum and a saturation flag and is purely combinational.
- The FSM, counters and output registers live in `adder_accumulator`.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles, then release. Expect `out_valid`=0, `acc_out`=0, `carry_cnt`=0, `overflow`=0, `in_ready`=1.
- Plain frame: 16 back-to-back samples with s=4'h3, c=0, `out_ready`=1. Expect `out_valid` the cycle after the 16th accept, `acc_out`=48, `carry_cnt`=0, `overflow`=0, and `in_ready` back to 1 one cycle later.
- Saturation: 16 samples with s=4'hF, c=1. Expect `acc_out`=255, `overflow`=1, `carry_cnt`=16. The saturation reaches 255 on the 9th sample, since 8×31=248 and 248+31>255.
- Backpressure and bubbles:
  - Frame with `in_valid` low every other cycle: only valid cycles count.
  - Then `out_ready`=0 for 5 cycles: `out_valid` and the results stay stable, `in_ready`=0, and samples offered meanwhile are ignored.
  - Then `out_ready`=1: the next frame starts from 0.
- Abort: accept 7 samples of 4'h5.
  - Pulse `clear`: next cycle `acc_out`=0 and `carry_cnt`=0, and the following 16 samples of 4'h1 give `acc_out`=16.
  - Repeat with `rst_n` pulsed low mid-frame: same result.
